uart_tx_framer: RTL and testbench

Parametrised UART transmit framer: accepts a parallel word over a valid/ready handshake and serialises it LSB-first as start bit, data bits, optional parity bit and one or two stop bits. Baud-rate timing is generated internally from a clock-per-bit divisor. The block sits between the transmit-side data source (FIFO or controller FSM) and the `tx` pad, replacing the fixed 11-bit frame shifter used previously.

---
 rtl/uart_tx_framer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, 1-2 stop bits at CLKS_PER_BIT cycles each.
// tx registered, first start-bit cycle one clock after accept; tx_ready only while idle, so sources are held off for a whole frame.
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_framer: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_framer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);
  localparam bit            ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          baud_cnt, baud_d;
  logic [BW-1:0]          bit_cnt, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign tx       = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '1;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx lines up with state.
  always_comb begin
    state_d = state;
    baud_d  = baud_end ? '0 : baud_cnt + 1'b1;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    case (state)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ ODD_PAR;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PAR : S_STOP;
            tx_d    = HAS_PAR ? par_q : 1'b1;
          end else begin
            bit_d = bit_cnt + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PAR: begin
        tx_d = par_q;
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bit_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: six framer configurations driven from one stimulus sequence,
// each frame compared against a bit-level waveform built from the frame rules and a mid-bit receiver.
module tb_uart_tx_framer;

  localparam int NI = 6;

  function automatic int cfg_cpb(input int k);
    return (k < 4) ? 4 : 2;
  endfunction
  function automatic int cfg_db(input int k);
    return (k == 3) ? 7 : (k == 4) ? 5 : (k == 5) ? 9 : 8;
  endfunction
  function automatic int cfg_par(input int k);
    return (k == 1 || k == 3) ? 2 : (k == 2 || k == 5) ? 1 : 0;
  endfunction
  function automatic int cfg_stp(input int k);
    return (k == 3 || k == 5) ? 2 : 1;
  endfunction
  function automatic int flen(input int k);
    return (1 + cfg_db(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_stp(k)) * cfg_cpb(k);
  endfunction
  function automatic logic [8:0] msk(input int k, input logic [8:0] d);
    logic [8:0] m;
    m = 9'((1 << cfg_db(k)) - 1);
    return d & m;
  endfunction

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    tx_data [NI];
  logic [NI-1:0] tx_valid;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit got_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_framer #(
      .DATA_BITS   (cfg_db(g)),
      .CLKS_PER_BIT(cfg_cpb(g)),
      .PARITY      (cfg_par(g)),
      .STOP_BITS   (cfg_stp(g))
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .tx_data (tx_data[g][cfg_db(g)-1:0]),
      .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]),
      .tx      (tx[g]),
      .busy    (busy[g])
    );
  end

  // Expected line levels for one frame, one entry per clock.
  task automatic push_frame(input int k, input logic [8:0] d);
    bit lv[$];
    int ones;
    lv.push_back(1'b0);
    for (int b = 0; b < cfg_db(k); b++) lv.push_back(d[b]);
    if (cfg_par(k) != 0) begin
      ones = $countones(d);
      lv.push_back((cfg_par(k) == 1) ? (ones % 2 == 0) : (ones % 2 == 1));
    end
    for (int s = 0; s < cfg_stp(k); s++) lv.push_back(1'b1);
    foreach (lv[j]) repeat (cfg_cpb(k)) exp_q.push_back(lv[j]);
  endtask

  function automatic logic [8:0] decode(input int k, input int off);
    logic [8:0] w;
    int c;
    w = '0;
    c = cfg_cpb(k);
    for (int b = 0; b < cfg_db(k); b++) w[b] = got_q[off + (1 + b) * c + c / 2];
    return w;
  endfunction

  task automatic wait_ready(input int k, input string tag);
    int n;
    n = 0;
    while (tx_ready[k] !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    assert (tx_ready[k] === 1'b1)
    else begin bad++; $error("FAIL %s ready_wait: tx_ready=%b expected=1", tag, tx_ready[k]); end
  endtask

  // Sends d0 (and d1 back-to-back when two=1) on instance k and checks line, handshake and decode.
  task automatic run_frames(input int k, input logic [8:0] d0, input logic [8:0] d1,
                            input bit two, input bit toggle, input string tag);
    int f, werr, herr, fall;
    bit exp_r;
    f = flen(k);
    exp_q.delete();
    got_q.delete();
    push_frame(k, d0);
    if (two) begin
      exp_q.push_back(1'b1);
      push_frame(k, d1);
    end
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    tx_data[k]  = d0;
    tx_valid[k] = 1'b1;
    wait_ready(k, tag);
    werr = 0;
    herr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      got_q.push_back(tx[k]);
      if (tx[k] !== exp_q[i]) werr++;
      exp_r = two ? (i == f || i >= 2 * f + 1) : (i >= f);
      if (tx_ready[k] !== exp_r || busy[k] !== !exp_r) herr++;
      if (i == 0 && two) tx_data[k] = d1;
      if ((i == 0 && !two) || (i == f + 1 && two)) tx_valid[k] = 1'b0;
      else if (toggle && !tx_valid[k]) tx_data[k] = 9'($urandom);
    end
    total++;
    assert (werr === 0)
    else begin bad++; $error("FAIL %s wave: mismatched_cycles=%0d expected=0", tag, werr); end
    total++;
    assert (herr === 0)
    else begin bad++; $error("FAIL %s handshake: mismatched_cycles=%0d expected=0", tag, herr); end
    total++;
    assert (decode(k, 0) === d0)
    else begin bad++; $error("FAIL %s rx_word0: got=%h expected=%h", tag, decode(k, 0), d0); end
    if (two) begin
      total++;
      assert (decode(k, f + 1) === d1)
      else begin bad++; $error("FAIL %s rx_word1: got=%h expected=%h", tag, decode(k, f + 1), d1); end
      fall = -1;
      for (int j = 1; j < got_q.size(); j++)
        if (fall < 0 && got_q[j-1] == 1'b1 && got_q[j] == 1'b0) fall = j;
      total++;
      assert (fall === f + 1)
      else begin bad++; $error("FAIL %s start_spacing: got=%0d expected=%0d", tag, fall, f + 1); end
    end
  endtask

  initial begin
    int err;
    logic [8:0] d;
    reset    = 1'b0;
    tx_valid = '0;
    for (int k = 0; k < NI; k++) tx_data[k] = '0;

    // Reset held with random inputs: line idle throughout.
    err = 0;
    repeat (8) begin
      @(posedge clk); #1;
      tx_valid = NI'($urandom);
      for (int k = 0; k < NI; k++) tx_data[k] = 9'($urandom);
      #1;
      if (tx !== '1 || tx_ready !== '1 || busy !== '0) err++;
    end
    total++;
    assert (err === 0)
    else begin bad++; $error("FAIL reset_hold: bad_cycles=%0d expected=0", err); end

    tx_valid = '0;
    reset    = 1'b1;
    err = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (tx !== '1 || tx_ready !== '1 || busy !== '0) err++;
    end
    total++;
    assert (err === 0)
    else begin bad++; $error("FAIL post_reset_idle: bad_cycles=%0d expected=0", err); end

    run_frames(0, 9'h0A5, 9'h000, 1'b0, 1'b1, "8N1_A5");
    run_frames(1, 9'h055, 9'h000, 1'b0, 1'b1, "8E1_55");
    run_frames(2, 9'h055, 9'h000, 1'b0, 1'b1, "8O1_55");
    run_frames(3, 9'h001, 9'h000, 1'b0, 1'b1, "7E2_01");
    run_frames(4, 9'h013, 9'h000, 1'b0, 1'b0, "5N1_13");
    run_frames(5, 9'h1A6, 9'h000, 1'b0, 1'b0, "9O2_1A6");
    run_frames(0, 9'h000, 9'h0FF, 1'b1, 1'b0, "b2b_00_FF");

    // Abort in data bit 3 of 0xA5 (line low there), then a clean frame.
    tx_data[0]  = 9'h0A5;
    tx_valid[0] = 1'b1;
    wait_ready(0, "abort");
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    total++;
    assert (tx[0] === 1'b0 && busy[0] === 1'b1)
    else begin bad++; $error("FAIL abort_pre: tx=%b busy=%b expected tx=0 busy=1", tx[0], busy[0]); end
    reset = 1'b0;
    #1;
    total++;
    assert (tx === '1 && tx_ready === '1 && busy === '0)
    else begin bad++; $error("FAIL abort_async: tx=%b rdy=%b busy=%b expected all idle", tx, tx_ready, busy); end
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    err = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1) err++;
    end
    total++;
    assert (err === 0)
    else begin bad++; $error("FAIL abort_no_resume: bad_cycles=%0d expected=0", err); end
    run_frames(0, 9'h03C, 9'h000, 1'b0, 1'b0, "after_abort_3C");

    for (int n = 0; n < 1000; n++) begin
      d = msk(n % NI, 9'($urandom));
      run_frames(n % NI, d, 9'h000, 1'b0, 1'b1, $sformatf("rand%0d_cfg%0d", n, n % NI));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
